risc_mc_ctrl: RTL

//  Multicycle control FSM for the RV32I-subset core (lw, sw, R-ALU, I-ALU, beq, jal).

---
 rtl/risc_mc_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/risc_mc_ctrl.sv
// Multicycle control FSM for the RV32I-subset core (lw, sw, R-ALU, I-ALU, beq, jal).
// Sequences fetch/decode/execute over a shared memory with a req/ack handshake,
// drives datapath selects, ALU control and write strobes, and counts retired instructions.
module risc_mc_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  zero,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            imm_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            alu_ctrl,
  output logic [1:0]            result_src,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  retired
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXR    = 4'd6,
    S_EXI    = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  state_t      state, state_nxt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [2:0]  funct_alu;
  logic        retire;
  logic        illegal_q;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

  // ALU operation selected by funct3; bit 30 picks sub only for register-register ops
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXR;
          OP_I:              state_nxt = S_EXI;
          OP_BEQ:            state_nxt = S_BEQ;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ack) state_nxt = S_MEMWB;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  if (mem_ack) state_nxt = S_FETCH;
      S_EXR:    state_nxt = S_ALUWB;
      S_EXI:    state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_BEQ:    state_nxt = S_FETCH;
      S_JAL:    state_nxt = S_ALUWB;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Output decode; everything is held low while reset is asserted
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    result_src = 2'b00;
    case (opcode)
      OP_STORE: imm_src = IMM_S;
      OP_BEQ:   imm_src = IMM_B;
      OP_JAL:   imm_src = IMM_J;
      default:  imm_src = IMM_I;
    endcase
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = funct_alu;
      end
      S_EXI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = funct_alu;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (!nrst) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      imm_src    = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b000;
      result_src = 2'b00;
    end
  end

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWR) && mem_ack);

  // Retired-instruction counter and sticky illegal-opcode flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      retired   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) retired <= retired + CNT_WIDTH'(1);
      if (state == S_DECODE && state_nxt == S_TRAP) illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;

endmodule
